// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter: one-deep L/R holding registers serialised into 64-bclk Philips I2S frames
module i2s_dac_transmitter #(
  parameter int HALF_DIV   = 16,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  l_data_en,
  input  logic                  r_data_en,
  input  logic [DATA_WIDTH-1:0] l_data,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  status_clr,
  output logic                  ready,
  output logic                  frame_start,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  s_data,
  output logic                  underrun,
  output logic                  overrun
);
  localparam int DIV_W = $clog2(2 * HALF_DIV);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [5:0] r_pos, w_pos_nxt;
  logic [DATA_WIDTH-1:0] r_l_hold, r_r_hold;
  logic [63:0] r_frame;
  logic r_l_full, r_r_full, w_l_full_nxt, w_r_full_nxt;
  logic w_div_wrap, w_boundary, w_load, w_take;
  logic r_ready, r_frame_start, r_bclk, r_lrclk, r_s_data, r_underrun, r_overrun;
  always_comb begin
    w_div_wrap   = r_div == DIV_W'(2 * HALF_DIV - 1);
    w_boundary   = r_state == IDLE || (w_div_wrap && r_pos == 6'd63);
    w_load       = w_boundary && enable;
    w_take       = w_load && r_l_full && r_r_full;
    w_state_nxt  = enable ? RUN : (w_boundary ? IDLE : DRAIN);
    w_div_nxt    = (w_boundary || w_div_wrap) ? '0 : r_div + DIV_W'(1);
    w_pos_nxt    = w_boundary ? '0 : r_pos + 6'(w_div_wrap);
    w_l_full_nxt = l_data_en || (r_l_full && !w_take);
    w_r_full_nxt = r_data_en || (r_r_full && !w_take);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_pos   <= w_pos_nxt;
    end
  end
  // Outputs are decoded from the next counter values so every output lines up with frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_l_full      <= 1'b0;
      r_r_full      <= 1'b0;
      r_l_hold      <= '0;
      r_r_hold      <= '0;
      r_frame       <= '0;
      r_ready       <= 1'b1;
      r_frame_start <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_s_data      <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_l_full <= w_l_full_nxt;
      r_r_full <= w_r_full_nxt;
      if (l_data_en) r_l_hold <= l_data;
      if (r_data_en) r_r_hold <= r_data;
      // Frame bit 63-pos is sent at pos; each slot leads with the one-bit delay.
      if (w_load) r_frame <= w_take ? (64'(r_l_hold) << (63 - DATA_WIDTH)) | (64'(r_r_hold) << (31 - DATA_WIDTH)) : '0;
      r_underrun    <= (w_load && !w_take) || (r_underrun && !status_clr);
      r_overrun     <= (((l_data_en && r_l_full) || (r_data_en && r_r_full)) && !w_take) || (r_overrun && !status_clr);
      r_ready       <= !w_l_full_nxt && !w_r_full_nxt;
      r_frame_start <= w_load;
      r_bclk        <= w_div_nxt >= DIV_W'(HALF_DIV);
      r_lrclk       <= w_pos_nxt[5];
      r_s_data      <= r_frame[~w_pos_nxt];
    end
  end
  assign ready       = r_ready;
  assign frame_start = r_frame_start;
  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign s_data      = r_s_data;
  assign underrun    = r_underrun;
  assign overrun     = r_overrun;
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// tb_i2s_dac_transmitter: vector table, corner sequences and random traffic against a cycle-count model
module tb_i2s_dac_transmitter;
  localparam int H = 2;
  localparam int DW = 24;
  localparam int PER = 2 * H;
  localparam int FRAME = 64 * PER;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, l_data_en = 1'b0, r_data_en = 1'b0, status_clr = 1'b0;
  logic [DW-1:0] l_data = '0, r_data = '0;
  logic ready, frame_start, bclk, lrclk, s_data, underrun, overrun;
  int n_tests = 0, n_fail = 0, n_cyc = 0;
  logic m_run = 1'b0, m_lf = 1'b0, m_rf = 1'b0, m_und = 1'b0, m_ovr = 1'b0, m_fs = 1'b0;
  int m_cnt = 0;
  logic [DW-1:0] m_lh = '0, m_rh = '0, m_lsh = '0, m_rsh = '0;
  logic [63:0] cap = '1;
  int fs_count = 0, fs_cyc = 0, fs_prev = 0, lr_rise = 0;
  logic lr_prev = 1'b0;
  logic ren = 1'b1;
  typedef struct {
    logic          dbl;
    logic [DW-1:0] l0, l, r, exp_l, exp_r;
    logic          exp_ovr;
  } vec_t;
  vec_t tbl [5];
  always #5 clk = ~clk;
  i2s_dac_transmitter #(.HALF_DIV(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .l_data_en(l_data_en), .r_data_en(r_data_en),
    .l_data(l_data), .r_data(r_data), .status_clr(status_clr), .ready(ready),
    .frame_start(frame_start), .bclk(bclk), .lrclk(lrclk), .s_data(s_data),
    .underrun(underrun), .overrun(overrun)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, n_cyc, act, exp);
    end
  endtask
  // Frames are tracked as a count of clk cycles since frame start, loads happen every FRAME cycles.
  task automatic model_step();
    logic both, load;
    if (reset) begin
      m_run = 0; m_cnt = 0; m_lf = 0; m_rf = 0; m_und = 0; m_ovr = 0; m_fs = 0;
      m_lh = '0; m_rh = '0; m_lsh = '0; m_rsh = '0;
    end else begin
      load = 0;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_cnt = 0; load = 1; end
      end else if (m_cnt == FRAME - 1) begin
        m_cnt = 0;
        if (enable) load = 1; else m_run = 0;
      end else m_cnt++;
      both = m_lf && m_rf;
      m_ovr = (((l_data_en && m_lf) || (r_data_en && m_rf)) && !(load && both)) || (m_ovr && !status_clr);
      m_und = (load && !both) || (m_und && !status_clr);
      if (load) begin
        m_lsh = both ? m_lh : '0;
        m_rsh = both ? m_rh : '0;
        if (both) begin m_lf = 0; m_rf = 0; end
      end
      if (l_data_en) begin m_lh = l_data; m_lf = 1; end
      if (r_data_en) begin m_rh = r_data; m_rf = 1; end
      m_fs = load;
    end
  endtask
  task automatic cyc(input logic e, input logic le, input logic re, input logic sc, input logic rs,
                     input logic [DW-1:0] ld, input logic [DW-1:0] rd);
    int p;
    logic sd;
    enable = e; l_data_en = le; r_data_en = re; status_clr = sc; reset = rs;
    if (le) l_data = ld;
    if (re) r_data = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    n_cyc++;
    p = m_cnt / PER;
    sd = 1'b0;
    if (m_run && p >= 1 && p <= DW) sd = m_lsh[DW - p];
    else if (m_run && p >= 33 && p <= 32 + DW) sd = m_rsh[32 + DW - p];
    chk("bclk", bclk, m_run && (m_cnt % PER) >= H);
    chk("lrclk", lrclk, m_run && p >= 32);
    chk("s_data", s_data, sd);
    chk("frame_start", frame_start, m_fs);
    chk("ready", ready, !m_lf && !m_rf);
    chk("underrun", underrun, m_und);
    chk("overrun", overrun, m_ovr);
    if (m_run && (m_cnt % PER) == H) cap[p] = s_data;
    if (frame_start) begin fs_count++; fs_prev = fs_cyc; fs_cyc = n_cyc; end
    if (lrclk && !lr_prev) lr_rise = n_cyc;
    lr_prev = lrclk;
  endtask
  task automatic run(input logic e);
    cyc(e, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask
  task automatic wait_load(input logic e);
    for (int k = 0; k < 2 * FRAME; k++) begin
      run(e);
      if (m_fs) return;
    end
    n_tests++; n_fail++;
    $display("FAIL wait_load: no frame start within %0d cycles", 2 * FRAME);
  endtask
  task automatic wait_cnt(input logic e, input int c);
    for (int k = 0; k < 2 * FRAME; k++) begin
      run(e);
      if (m_run && m_cnt == c) return;
    end
    n_tests++; n_fail++;
    $display("FAIL wait_cnt: position %0d not reached", c);
  endtask
  function automatic logic [DW-1:0] dec(input int base);
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) v[DW-1-i] = cap[base + i];
    return v;
  endfunction
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{1'b0, 24'h000000, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 1'b0};
    tbl[1] = '{1'b0, 24'h000000, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 1'b0};
    tbl[2] = '{1'b1, 24'h123456, 24'h654321, 24'h0FEDCB, 24'h654321, 24'h0FEDCB, 1'b1};
    tbl[3] = '{1'b0, 24'h000000, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001, 1'b0};
    tbl[4] = '{1'b0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b0};
    cyc(0, 0, 0, 0, 1, '0, '0);
    cyc(0, 0, 0, 0, 1, '0, '0);
    chk("rst_ready", ready, 1);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", s_data, 0);
    chk("rst_flags", {underrun, overrun, frame_start}, 0);
    run(0);
    for (int i = 0; i < 5; i++) begin
      logic e;
      e = (i > 0);
      cyc(e, 0, 0, 1, 0, '0, '0);
      if (tbl[i].dbl) cyc(e, 1, 0, 0, 0, tbl[i].l0, '0);
      cyc(e, 1, 0, 0, 0, tbl[i].l, '0);
      cyc(e, 0, 1, 0, 0, '0, tbl[i].r);
      chk("tbl_overrun", overrun, tbl[i].exp_ovr);
      chk("tbl_ready_full", ready, 0);
      cap = '1;
      fs_count = 0;
      wait_load(1);
      chk("tbl_ready_after_load", ready, 1);
      repeat (FRAME - 26) run(1);
      chk("tbl_left", dec(1), tbl[i].exp_l);
      chk("tbl_right", dec(33), tbl[i].exp_r);
      chk("tbl_pad", {cap[32:25], cap[0]}, 0);
      chk("tbl_fs_once", fs_count, 1);
      if (i == 0) chk("lrclk_offset", 32'(lr_rise - fs_cyc), FRAME / 2);
      else chk("frame_len", 32'(fs_cyc - fs_prev), FRAME);
    end
    cyc(1, 0, 0, 1, 0, '0, '0);
    wait_load(1);
    chk("und_set", underrun, 1);
    cyc(1, 0, 0, 1, 0, '0, '0);
    chk("und_clr", underrun, 0);
    cap = '1;
    repeat (FRAME - 27) run(1);
    chk("und_zero_l", dec(1), 0);
    chk("und_zero_r", dec(33), 0);
    wait_load(1);
    chk("und_again", underrun, 1);
    cyc(1, 1, 0, 0, 0, 24'h111111, '0);
    cyc(1, 0, 1, 0, 0, '0, 24'h222222);
    wait_cnt(1, FRAME - 1);
    cap = '1;
    cyc(1, 1, 0, 0, 0, 24'h333333, '0);
    chk("sim_fs", frame_start, 1);
    chk("sim_ovr", overrun, 0);
    chk("sim_ready", ready, 0);
    repeat (FRAME - 26) run(1);
    chk("sim_old_l", dec(1), 24'h111111);
    chk("sim_r", dec(33), 24'h222222);
    cyc(1, 0, 1, 0, 0, '0, 24'h444444);
    cap = '1;
    wait_load(1);
    chk("sim_ovr_held", overrun, 0);
    repeat (FRAME - 26) run(1);
    chk("sim_new_l", dec(1), 24'h333333);
    chk("sim_new_r", dec(33), 24'h444444);
    wait_cnt(1, 10 * PER);
    for (int k = 0; k < 2 * FRAME; k++) begin
      run(0);
      if (!m_run) break;
    end
    chk("drain_bclk", bclk, 0);
    chk("drain_lrclk", lrclk, 0);
    chk("drain_sdata", s_data, 0);
    fs_count = 0;
    repeat (5) run(0);
    chk("drain_no_fs", fs_count, 0);
    wait_load(1);
    wait_cnt(1, 10 * PER);
    wait_cnt(0, 40 * PER);
    wait_load(1);
    chk("drain_resume_len", 32'(fs_cyc - fs_prev), FRAME);
    cyc(1, 1, 0, 0, 0, 24'hABCDEF, '0);
    cyc(1, 1, 0, 0, 0, 24'hFEDCBA, '0);
    wait_cnt(1, 40 * PER);
    chk("pre_rst_lrclk", lrclk, 1);
    chk("pre_rst_ovr", overrun, 1);
    cyc(1, 0, 0, 0, 1, '0, '0);
    chk("rst40_bclk", bclk, 0);
    chk("rst40_lrclk", lrclk, 0);
    chk("rst40_sdata", s_data, 0);
    chk("rst40_ready", ready, 1);
    chk("rst40_sticky", {underrun, overrun, frame_start}, 0);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) ren = ~ren;
      cyc(ren, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 999) == 0, 24'($urandom), 24'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
